// File: rtl/immediate_generator_pkg.sv
// ImmediatePkg: immediate-format encoding shared by decode and the immediate generator,
// plus the generator's prefix state type.
package ImmediatePkg;
    typedef enum logic [2:0] {
        IMM_NONE   = 3'd0,
        IMM_SEXT   = 3'd1,
        IMM_ZEXT   = 3'd2,
        IMM_UPPER  = 3'd3,
        IMM_PREFIX = 3'd4
    } imm_format_e;
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_PREFIXED = 1'b1
    } imm_state_e;
endpackage

// File: rtl/immediate_extend.sv
// immediate_extend: combinational immediate value formation.
// Ports: fmt_i (format code), field_i (raw field), prefix_i/prefixed_i (held prefix and
// whether it applies), imm_en_o/upper_en_o (operand-B selects), value_o (immediate).
// Codes 4-7 produce the NONE result; the caller decides what a PREFIX means.
module immediate_extend
    import ImmediatePkg::*;
#(
    parameter int DATABITWIDTH  = 16,
    parameter int IMMFIELDWIDTH = 8
) (
    input  logic [2:0]               fmt_i,
    input  logic [IMMFIELDWIDTH-1:0] field_i,
    input  logic [IMMFIELDWIDTH-1:0] prefix_i,
    input  logic                     prefixed_i,
    output logic                     imm_en_o,
    output logic                     upper_en_o,
    output logic [DATABITWIDTH-1:0]  value_o
);
    localparam int PADW = DATABITWIDTH - IMMFIELDWIDTH;
    logic is_ext;
    always_comb begin
        is_ext     = fmt_i == IMM_SEXT || fmt_i == IMM_ZEXT;
        imm_en_o   = is_ext || fmt_i == IMM_UPPER;
        upper_en_o = fmt_i == IMM_UPPER;
        // A pending prefix supplies the upper half verbatim, so no extension applies.
        value_o    = (is_ext && prefixed_i) ? {prefix_i, field_i} :
                     fmt_i == IMM_SEXT      ? {{PADW{field_i[IMMFIELDWIDTH-1]}}, field_i} :
                     fmt_i == IMM_ZEXT      ? {{PADW{1'b0}}, field_i} :
                     fmt_i == IMM_UPPER     ? {field_i, {PADW{1'b0}}} : '0;
    end
endmodule

// File: rtl/immediate_generator.sv
// immediate_generator: one-stage registered immediate generator with valid/ready handshake.
// Ports: clk, clear (async active-high reset), FlushIn (sync flush), InValid/InReady (decode
// side), ImmFormatIn/ImmFieldIn (format code and raw field), OutValid/OutReady (execute side),
// ImmediateEn/UpperImmediateEn/ImmediateOut (registered operand-B controls and value),
// PrefixDroppedOut (pulse when a pending prefix is discarded).
// Define IMMEDIATE_PREFIX_EN to build PREFIX support; otherwise PREFIX behaves as NONE.
module immediate_generator
    import ImmediatePkg::*;
#(
    parameter int DATABITWIDTH  = 16,
    parameter int IMMFIELDWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     FlushIn,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [2:0]               ImmFormatIn,
    input  logic [IMMFIELDWIDTH-1:0] ImmFieldIn,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic                     ImmediateEn,
    output logic                     UpperImmediateEn,
    output logic [DATABITWIDTH-1:0]  ImmediateOut,
    output logic                     PrefixDroppedOut
);
    logic                     out_valid_q, out_valid_d;
    logic                     imm_en_q, imm_en_d;
    logic                     upper_en_q, upper_en_d;
    logic [DATABITWIDTH-1:0]  imm_q, imm_d;
    logic                     xfer, load, is_prefix, prefixed;
    logic [IMMFIELDWIDTH-1:0] prefix_val;
    logic                     ext_en, ext_upper;
    logic [DATABITWIDTH-1:0]  ext_val;

    assign InReady = !out_valid_q || OutReady;
    assign xfer    = InValid && InReady;

`ifdef IMMEDIATE_PREFIX_EN
    imm_state_e               state_q, state_d;
    logic [IMMFIELDWIDTH-1:0] prefix_q, prefix_d;
    logic                     dropped_q, dropped_d;
    assign is_prefix        = ImmFormatIn == IMM_PREFIX;
    assign prefixed         = state_q == ST_PREFIXED;
    assign prefix_val       = prefix_q;
    assign PrefixDroppedOut = dropped_q;
    always_comb begin
        state_d   = FlushIn ? ST_IDLE : xfer ? (is_prefix ? ST_PREFIXED : ST_IDLE) : state_q;
        prefix_d  = FlushIn ? '0 : (xfer && is_prefix) ? ImmFieldIn : prefix_q;
        // Only SEXT/ZEXT consume a pending prefix; anything else accepted discards it.
        dropped_d = !FlushIn && xfer && prefixed &&
                    !(ImmFormatIn == IMM_SEXT || ImmFormatIn == IMM_ZEXT);
    end
`else
    assign is_prefix        = 1'b0;
    assign prefixed         = 1'b0;
    assign prefix_val       = '0;
    assign PrefixDroppedOut = 1'b0;
`endif

    immediate_extend #(
        .DATABITWIDTH (DATABITWIDTH),
        .IMMFIELDWIDTH(IMMFIELDWIDTH)
    ) u_extend (
        .fmt_i     (ImmFormatIn),
        .field_i   (ImmFieldIn),
        .prefix_i  (prefix_val),
        .prefixed_i(prefixed),
        .imm_en_o  (ext_en),
        .upper_en_o(ext_upper),
        .value_o   (ext_val)
    );

    always_comb begin
        load        = xfer && !is_prefix && !FlushIn;
        out_valid_d = !FlushIn && (load || (out_valid_q && !OutReady));
        imm_en_d    = load ? ext_en : imm_en_q;
        upper_en_d  = load ? ext_upper : upper_en_q;
        imm_d       = load ? ext_val : imm_q;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            out_valid_q <= 1'b0;
            imm_en_q    <= 1'b0;
            upper_en_q  <= 1'b0;
            imm_q       <= '0;
`ifdef IMMEDIATE_PREFIX_EN
            state_q     <= ST_IDLE;
            prefix_q    <= '0;
            dropped_q   <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            imm_en_q    <= imm_en_d;
            upper_en_q  <= upper_en_d;
            imm_q       <= imm_d;
`ifdef IMMEDIATE_PREFIX_EN
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            dropped_q   <= dropped_d;
`endif
        end
    end

    assign OutValid         = out_valid_q;
    assign ImmediateEn      = imm_en_q;
    assign UpperImmediateEn = upper_en_q;
    assign ImmediateOut     = imm_q;
endmodule

// File: tb/tb_immediate_generator.sv
// tb_immediate_generator: vector table, directed corner sequences and random traffic
// against a behavioural model of the immediate generator.
module tb_immediate_generator;
    logic        clk = 1'b0;
    logic        clear, FlushIn, InValid, InReady, OutValid, OutReady;
    logic        ImmediateEn, UpperImmediateEn, PrefixDroppedOut;
    logic [2:0]  ImmFormatIn;
    logic [7:0]  ImmFieldIn;
    logic [15:0] ImmediateOut;

    always #5 clk = ~clk;

`ifdef IMMEDIATE_PREFIX_EN
    localparam bit PFX_EN = 1'b1;
`else
    localparam bit PFX_EN = 1'b0;
`endif

    immediate_generator #(.DATABITWIDTH(16), .IMMFIELDWIDTH(8)) dut (
        .clk(clk), .clear(clear), .FlushIn(FlushIn), .InValid(InValid), .InReady(InReady),
        .ImmFormatIn(ImmFormatIn), .ImmFieldIn(ImmFieldIn), .OutValid(OutValid),
        .OutReady(OutReady), .ImmediateEn(ImmediateEn), .UpperImmediateEn(UpperImmediateEn),
        .ImmediateOut(ImmediateOut), .PrefixDroppedOut(PrefixDroppedOut)
    );

    int n_cmp = 0, n_err = 0;
    logic mv = 0, men = 0, mup = 0, mdrop = 0, pv = 0;
    logic [15:0] mval = 0;
    int pfx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, written from the handshake/format rules.
    task automatic model_update();
        int f = int'(ImmFieldIn);
        int v;
        bit xf = InValid && (!mv || OutReady);
        bit ext = ImmFormatIn == 3'd1 || ImmFormatIn == 3'd2;
        mdrop = 0;
        if (FlushIn) begin
            mv = 0; pv = 0; pfx = 0;
        end else if (xf && PFX_EN && ImmFormatIn == 3'd4) begin
            mdrop = pv; pv = 1; pfx = f; mv = 0;
        end else if (xf) begin
            men = ImmFormatIn inside {[3'd1:3'd3]};
            mup = ImmFormatIn == 3'd3;
            if (ext) v = pv ? pfx * 256 + f : (ImmFormatIn == 3'd1 && f >= 128) ? f - 256 : f;
            else v = (ImmFormatIn == 3'd3) ? f * 256 : 0;
            mval = v[15:0];
            mdrop = pv && !ext;
            mv = 1; pv = 0;
        end else if (OutReady) begin
            mv = 0;
        end
    endtask

    task automatic check_outputs();
        check("OutValid", OutValid, mv);
        check("PrefixDropped", PrefixDroppedOut, mdrop);
        if (mv) begin
            check("ImmediateEn", ImmediateEn, men);
            check("UpperImmediateEn", UpperImmediateEn, mup);
            check("ImmediateOut", ImmediateOut, mval);
        end
    endtask

    task automatic cycle(input logic v, input logic fl, input logic [2:0] fmt,
                         input logic [7:0] fld, input logic rdy);
        InValid = v; FlushIn = fl; ImmFormatIn = fmt; ImmFieldIn = fld; OutReady = rdy;
        #1 check("InReady", InReady, !mv || rdy);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_clear();
        clear = 1'b1;
        #1;
        mv = 0; men = 0; mup = 0; mval = 0; mdrop = 0; pv = 0; pfx = 0;
        check("clr_OutValid", OutValid, 0);
        check("clr_ImmediateEn", ImmediateEn, 0);
        check("clr_UpperEn", UpperImmediateEn, 0);
        check("clr_ImmediateOut", ImmediateOut, 0);
        check("clr_Dropped", PrefixDroppedOut, 0);
        #1 clear = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  fmt;
        logic [7:0]  fld;
        logic        en;
        logic        up;
        logic [15:0] val;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{3'd1, 8'h80, 1'b1, 1'b0, 16'hFF80};
        tbl[1] = '{3'd2, 8'h80, 1'b1, 1'b0, 16'h0080};
        tbl[2] = '{3'd3, 8'hA5, 1'b1, 1'b1, 16'hA500};
        tbl[3] = '{3'd0, 8'h5A, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{3'd1, 8'h7F, 1'b1, 1'b0, 16'h007F};
        tbl[5] = '{3'd1, 8'hFF, 1'b1, 1'b0, 16'hFFFF};
        tbl[6] = '{3'd2, 8'hFF, 1'b1, 1'b0, 16'h00FF};
        tbl[7] = '{3'd5, 8'h33, 1'b0, 1'b0, 16'h0000};
        tbl[8] = '{3'd7, 8'hC3, 1'b0, 1'b0, 16'h0000};
        tbl[9] = '{3'd3, 8'h01, 1'b1, 1'b1, 16'h0100};

        clear = 1'b1; FlushIn = 0; InValid = 0; ImmFormatIn = 0; ImmFieldIn = 0; OutReady = 1;
        #2;
        check("rst_OutValid", OutValid, 0);
        check("rst_ImmediateEn", ImmediateEn, 0);
        check("rst_UpperEn", UpperImmediateEn, 0);
        check("rst_ImmediateOut", ImmediateOut, 0);
        check("rst_Dropped", PrefixDroppedOut, 0);
        check("rst_InReady", InReady, 1);
        @(negedge clk);
        clear = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, tbl[i].fmt, tbl[i].fld, 1);
            check("tbl_valid", OutValid, 1);
            check("tbl_en", ImmediateEn, tbl[i].en);
            check("tbl_up", UpperImmediateEn, tbl[i].up);
            check("tbl_val", ImmediateOut, tbl[i].val);
        end
        cycle(0, 0, 0, 0, 1);

        cycle(1, 0, 3'd4, 8'h12, 1);
        check("pfx_no_out", OutValid, !PFX_EN);
        cycle(1, 0, 3'd1, 8'h84, 1);
        check("pfx_sext", ImmediateOut, PFX_EN ? 16'h1284 : 16'hFF84);

        cycle(1, 0, 3'd4, 8'h12, 1);
        cycle(1, 0, 3'd3, 8'h34, 1);
        check("pfx_upper", ImmediateOut, 16'h3400);
        check("pfx_drop", PrefixDroppedOut, PFX_EN);
        cycle(1, 0, 3'd2, 8'h01, 1);
        check("after_drop", ImmediateOut, 16'h0001);
        check("drop_once", PrefixDroppedOut, 0);

        cycle(1, 0, 3'd2, 8'h11, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 3'd1, 8'h22, 0);
            check("stall_ready", InReady, 0);
            check("stall_hold", ImmediateOut, 16'h0011);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 3'd2, 8'h40 + 8'(k), 1);
            check("b2b_valid", OutValid, 1);
            check("b2b_val", ImmediateOut, 16'h0040 + 16'(k));
        end

        cycle(1, 0, 3'd4, 8'h12, 1);
        cycle(1, 1, 3'd1, 8'h55, 1);
        check("flush_valid", OutValid, 0);
        check("flush_nodrop", PrefixDroppedOut, 0);
        cycle(1, 0, 3'd2, 8'h34, 1);
        check("flush_next", ImmediateOut, 16'h0034);

        cycle(1, 0, 3'd4, 8'h12, 1);
        async_clear();
        cycle(1, 0, 3'd2, 8'h34, 1);
        check("clear_next", ImmediateOut, 16'h0034);
        check("clear_nodrop", PrefixDroppedOut, 0);

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                  3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/immediate_generator.md
IMMEDIATE_GENERATOR -- requirements
Module: immediate_generator

Interface
REQ-001 SHALL have parameter DATABITWIDTH, default 16, meaning operand/immediate output width.
REQ-002 SHALL have parameter IMMFIELDWIDTH, default 8, meaning raw instruction immediate field width, required equal to DATABITWIDTH/2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port FlushIn  input  1  synchronous pipeline flush.
REQ-006 SHALL have ports InValid  input  1  and InReady  output  1: upstream decode handshake.
REQ-007 SHALL have port ImmFormatIn  input  3  immediate format: 0 NONE, 1 SEXT, 2 ZEXT, 3 UPPER, 4 PREFIX; 5-7 treated as NONE.
REQ-008 SHALL have port ImmFieldIn  input  IMMFIELDWIDTH  raw immediate field.
REQ-009 SHALL have ports OutValid  output  1  and OutReady  input  1: downstream execute-stage handshake.
REQ-010 SHALL have ports ImmediateEn  output  1, UpperImmediateEn  output  1, ImmediateOut  output  DATABITWIDTH: registered operand-B select controls and immediate value.
REQ-011 SHALL have port PrefixDroppedOut  output  1  one-cycle pulse when a pending prefix is discarded.

Function
REQ-012 SHALL hold one output register stage; an accepted non-PREFIX transfer appears on outputs the next cycle (latency 1).
REQ-013 SHALL drive InReady = !OutValid || OutReady, combinationally; transfer occurs when InValid && InReady.
REQ-014 SHALL sustain one transfer per cycle when OutReady is held high.
REQ-015 SHALL hold all outputs stable while OutValid && !OutReady.
REQ-016 SHALL on NONE emit ImmediateEn=0, UpperImmediateEn=0, ImmediateOut=0.
REQ-017 SHALL on SEXT emit ImmediateEn=1, UpperImmediateEn=0, ImmediateOut = ImmFieldIn sign-extended to DATABITWIDTH.
REQ-018 SHALL on ZEXT emit ImmediateEn=1, UpperImmediateEn=0, ImmediateOut = ImmFieldIn zero-extended.
REQ-019 SHALL on UPPER emit ImmediateEn=1, UpperImmediateEn=1, ImmediateOut = {ImmFieldIn, zeros} (field in upper half).
REQ-020 SHALL implement state machine IDLE/PREFIXED with a PrefixReg of IMMFIELDWIDTH bits.
REQ-021 SHALL on accepted PREFIX store ImmFieldIn to PrefixReg, enter PREFIXED, load nothing into the output register (OutValid clears if current output consumed that cycle).
REQ-022 SHALL in PREFIXED on accepted SEXT or ZEXT emit ImmediateEn=1, UpperImmediateEn=0, ImmediateOut = {PrefixReg, ImmFieldIn} with no extension, and return to IDLE.
REQ-023 SHALL in PREFIXED on accepted PREFIX overwrite PrefixReg, stay PREFIXED, pulse PrefixDroppedOut.
REQ-024 SHALL in PREFIXED on accepted NONE or UPPER emit per REQ-016/019, return to IDLE, pulse PrefixDroppedOut.
REQ-025 SHALL on FlushIn clear OutValid, return to IDLE, clear PrefixReg, ignore same-cycle input (InReady still per REQ-013, transfer discarded); no PrefixDroppedOut pulse.

Reset
REQ-026 SHALL on clear asynchronously set OutValid=0, ImmediateEn=0, UpperImmediateEn=0, ImmediateOut=0, PrefixDroppedOut=0, PrefixReg=0, state IDLE.
REQ-027 SHALL, on clear asserted mid-PREFIXED, discard the prefix with no PrefixDroppedOut pulse.

Configuration
REQ-028 SHALL compile PREFIX support only when IMMEDIATE_PREFIX_EN is defined.
REQ-029 SHALL without IMMEDIATE_PREFIX_EN omit state machine and PrefixReg, treat PREFIX as NONE, tie PrefixDroppedOut to 0.

Structure
REQ-030 SHALL place the immediate format enumeration (NONE..PREFIX, 3-bit) in the shared ImmediatePkg package used by decode and this block.
REQ-031 SHALL implement the SEXT/ZEXT/UPPER/prefix-concatenation value formation in one combinational sub-module immediate_extend.

Verification (DATABITWIDTH=16, IMMFIELDWIDTH=8)
REQ-032 SHALL cover: SEXT 0x80 -> next cycle OutValid=1, ImmediateOut=0xFF80, ImmediateEn=1, UpperImmediateEn=0; ZEXT 0x80 -> 0x0080.
REQ-033 SHALL cover: UPPER 0xA5 -> ImmediateOut=0xA500, ImmediateEn=1, UpperImmediateEn=1.
REQ-034 SHALL cover: PREFIX 0x12 then SEXT 0x84 -> single output 0x1284, no output for PREFIX; with macro undefined PREFIX 0x12 -> NONE output, then 0xFF84.
REQ-035 SHALL cover: PREFIX 0x12 then UPPER 0x34 -> 0x3400 and PrefixDroppedOut pulse; following ZEXT 0x01 -> 0x0001.
REQ-036 SHALL cover: OutReady=0 for 3 cycles with InValid=1 -> InReady=0, outputs held; OutReady=1 -> back-to-back transfers each cycle.
REQ-037 SHALL cover: FlushIn and clear each asserted in PREFIXED -> OutValid=0, next ZEXT 0x34 -> 0x0034.
